// File: rtl/fp_to_int_converter.sv
// Multi-cycle IEEE-754 single-precision to int32 converter (truncation toward zero).
// The significand is aligned by a barrel of STEP bits per SHIFT cycle, then signed/saturated in FIX.
module fp_to_int_converter #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;
  typedef enum logic [2:0] {K_NUM, K_ZERO, K_NAN, K_SAT, K_MIN} kind_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state_reg, state_next;
  kind_t       kind_reg, kind_next, kind_dec;
  logic [31:0] mag_reg, mag_next;
  logic [4:0]  cnt_reg, cnt_next, cnt_dec, shift_amt, cnt_rem;
  logic        left_reg, left_next, left_dec;
  logic        sign_reg, sign_next;
  logic [31:0] result_reg, result_next;
  logic        overflow_reg, overflow_next;
  logic        invalid_reg, invalid_next;

  logic [7:0]  exp_a;
  logic [22:0] mant_a;

  assign exp_a  = a[30:23];
  assign mant_a = a[22:0];

  // Classify the operand and work out the alignment distance relative to 2^23.
  always_comb begin
    kind_dec = K_NUM;
    cnt_dec  = '0;
    left_dec = 1'b0;
    if (exp_a == 8'd255) begin
      kind_dec = (mant_a != '0) ? K_NAN : K_SAT;
    end else if (exp_a < 8'd127) begin
      kind_dec = K_ZERO;
    end else if (exp_a >= 8'd158) begin
      kind_dec = (a[31] && exp_a == 8'd158 && mant_a == '0) ? K_MIN : K_SAT;
    end else if (exp_a >= 8'd150) begin
      left_dec = 1'b1;
      cnt_dec  = 5'(exp_a - 8'd150);
    end else begin
      cnt_dec  = 5'(8'd150 - exp_a);
    end
  end

  assign shift_amt = (cnt_reg < STEP_AMT) ? cnt_reg : STEP_AMT;
  assign cnt_rem   = cnt_reg - shift_amt;

  always_comb begin
    state_next    = state_reg;
    kind_next     = kind_reg;
    mag_next      = mag_reg;
    cnt_next      = cnt_reg;
    left_next     = left_reg;
    sign_next     = sign_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    invalid_next  = invalid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = a[31];
          kind_next  = kind_dec;
          mag_next   = {8'd0, 1'b1, mant_a};
          cnt_next   = cnt_dec;
          left_next  = left_dec;
          state_next = (kind_dec == K_NUM && cnt_dec != '0) ? SHIFT : FIX;
        end
      end
      SHIFT: begin
        mag_next = left_reg ? (mag_reg << shift_amt) : (mag_reg >> shift_amt);
        cnt_next = cnt_rem;
        if (cnt_rem == '0) state_next = FIX;
      end
      FIX: begin
        overflow_next = 1'b0;
        invalid_next  = 1'b0;
        case (kind_reg)
          K_NUM:   result_next = sign_reg ? -mag_reg : mag_reg;
          K_NAN: begin
            result_next  = '0;
            invalid_next = 1'b1;
          end
          K_SAT: begin
            result_next   = sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            overflow_next = 1'b1;
          end
          K_MIN:   result_next = 32'h8000_0000;
          default: result_next = '0;
        endcase
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      kind_reg     <= K_ZERO;
      mag_reg      <= '0;
      cnt_reg      <= '0;
      left_reg     <= 1'b0;
      sign_reg     <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      invalid_reg  <= 1'b0;
    end else if (en) begin
      state_reg    <= state_next;
      kind_reg     <= kind_next;
      mag_reg      <= mag_next;
      cnt_reg      <= cnt_next;
      left_reg     <= left_next;
      sign_reg     <= sign_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      invalid_reg  <= invalid_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign overflow  = overflow_reg;
  assign invalid   = invalid_reg;

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Bench for fp_to_int_converter: STEP=1 and STEP=4 instances, integer-arithmetic reference model
// plus directed vectors with hand-computed results and latencies.
module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_s        [2];
  logic [31:0] a_s         [2];
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [31:0] result_s    [2];
  logic        overflow_s  [2];
  logic        invalid_s   [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_to_int_converter #(.STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en_s[0]), .a(a_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .result(result_s[0]), .overflow(overflow_s[0]),
    .invalid(invalid_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0])
  );

  fp_to_int_converter #(.STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en_s[1]), .a(a_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .result(result_s[1]), .overflow(overflow_s[1]),
    .invalid(invalid_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1])
  );

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        v;
    int          lat;
  } exp_t;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  // Reference: exact value sig*2^(E-23) truncated, then clamped into int32 range.
  function automatic exp_t model(input logic [31:0] x, input int step);
    exp_t   m;
    int     e;
    int     ee;
    int     k;
    longint sig;
    longint v;
    e     = int'(x[30:23]);
    ee    = e - 127;
    sig   = longint'({1'b1, x[22:0]});
    m.r   = 32'd0;
    m.o   = 1'b0;
    m.v   = 1'b0;
    m.lat = 2;
    if (e == 255 && x[22:0] != 23'd0) begin
      m.v = 1'b1;
    end else if (e == 255 || ee >= 32) begin
      m.r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      m.o = 1'b1;
    end else if (ee >= 0) begin
      v = (ee >= 23) ? (sig << (ee - 23)) : (sig >> (23 - ee));
      if (x[31]) v = -v;
      if (v > MAXI) begin
        m.r = 32'h7FFF_FFFF; m.o = 1'b1;
      end else if (v < MINI) begin
        m.r = 32'h8000_0000; m.o = 1'b1;
      end else begin
        m.r = v[31:0];
      end
      if (ee <= 30) begin
        k = (ee >= 23) ? ee - 23 : 23 - ee;
        m.lat = 2 + (k + step - 1) / step;
      end
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  // Monitor: capture model expectation on accept, count enabled edges until DONE.
  exp_t mon_exp  [2];
  logic mon_pend [2] = '{1'b0, 1'b0};
  int   mon_lat  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset !== 1'b1) begin
        mon_pend[i] <= 1'b0;
      end else if (en_s[i]) begin
        if (in_valid_s[i] && in_ready_s[i]) begin
          mon_pend[i] <= 1'b1;
          mon_lat[i]  <= 1;
          mon_exp[i]  <= model(a_s[i], (i == 0) ? 1 : 4);
        end else if (mon_pend[i] && out_valid_s[i] && out_ready_s[i]) begin
          mon_pend[i] <= 1'b0;
        end else if (mon_pend[i] && !out_valid_s[i]) begin
          mon_lat[i] <= mon_lat[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (out_valid_s[i] === 1'b1) begin
        if (!mon_pend[i]) begin
          n_cmp++;
          n_fail++;
          $display("FAIL inst%0d_spurious_out_valid: got out_valid=1 required 0", i);
        end else begin
          chk($sformatf("mon%0d_result", i), result_s[i], mon_exp[i].r);
          chk($sformatf("mon%0d_overflow", i), 32'(overflow_s[i]), 32'(mon_exp[i].o));
          chk($sformatf("mon%0d_invalid", i), 32'(invalid_s[i]), 32'(mon_exp[i].v));
          chk($sformatf("mon%0d_latency", i), 32'(mon_lat[i]), 32'(mon_exp[i].lat));
        end
      end
    end
  end

  task automatic start(input int i, input logic [31:0] x);
    @(negedge clk);
    chk($sformatf("inst%0d_in_ready_before_%h", i, x), 32'(in_ready_s[i]), 32'd1);
    a_s[i]        = x;
    in_valid_s[i] = 1'b1;
    @(negedge clk);
    in_valid_s[i] = 1'b0;
    a_s[i]        = 32'hDEAD_BEEF;
  endtask

  // Counts every edge from the accept edge (inclusive); stalls en for 3 edges at stall_at.
  task automatic wait_valid(input int i, input int stall_at, output int lat);
    lat = 1;
    while (out_valid_s[i] !== 1'b1 && lat < 200) begin
      if (lat == stall_at)     en_s[i] = 1'b0;
      if (lat == stall_at + 3) en_s[i] = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) chk($sformatf("inst%0d_timeout", i), 32'(out_valid_s[i]), 32'd1);
  endtask

  task automatic convert(input int i, input logic [31:0] x, input logic [31:0] er,
                         input logic eo, input logic ev, input int elat, input int stall_at);
    int lat;
    start(i, x);
    wait_valid(i, stall_at, lat);
    $display("inst%0d a=%h result=%h ovf=%b inv=%b latency=%0d", i, x, result_s[i],
             overflow_s[i], invalid_s[i], lat);
    chk($sformatf("inst%0d_%h_result", i, x), result_s[i], er);
    chk($sformatf("inst%0d_%h_overflow", i, x), 32'(overflow_s[i]), 32'(eo));
    chk($sformatf("inst%0d_%h_invalid", i, x), 32'(invalid_s[i]), 32'(ev));
    chk($sformatf("inst%0d_%h_latency", i, x), 32'(lat), 32'(elat));
    @(negedge clk);
    chk($sformatf("inst%0d_%h_idle_after", i, x), 32'(in_ready_s[i]), 32'd1);
    chk($sformatf("inst%0d_%h_valid_cleared", i, x), 32'(out_valid_s[i]), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s%0d_result", tag, i), result_s[i], 32'd0);
      chk($sformatf("%s%0d_flags", tag, i), 32'({overflow_s[i], invalid_s[i]}), 32'd0);
      chk($sformatf("%s%0d_out_valid", tag, i), 32'(out_valid_s[i]), 32'd0);
      chk($sformatf("%s%0d_in_ready", tag, i), 32'(in_ready_s[i]), 32'd1);
    end
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en_s[i] = 1'b1; a_s[i] = '0; in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b1;

    // STEP=1 numeric, special and boundary vectors
    convert(0, 32'h422A_CCCD, 32'h0000_002A, 1'b0, 1'b0, 20, -1);
    convert(0, 32'hC16F_D708, 32'hFFFF_FFF2, 1'b0, 1'b0, 22, -1);
    convert(0, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0,  9, -1);
    convert(0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, -1);
    convert(0, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0,  2, -1);
    convert(0, 32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0,  2, -1);
    convert(0, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, -1);
    convert(0, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0,  2, -1);
    convert(0, 32'h7F80_0001, 32'h0000_0000, 1'b0, 1'b1,  2, -1);
    convert(0, 32'h5F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  2, -1);
    convert(0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0,  2, -1);
    convert(0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0,  2, -1);
    convert(0, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0,  2, -1);
    convert(0, 32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0,  2, -1);
    convert(0, 32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 25, -1);

    // STEP=4 instance
    convert(1, 32'h422A_CCCD, 32'h0000_002A, 1'b0, 1'b0,  7, -1);
    convert(1, 32'hC16F_D708, 32'hFFFF_FFF2, 1'b0, 1'b0,  7, -1);
    convert(1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0,  4, -1);
    convert(1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0,  8, -1);

    // en low for 3 edges mid-SHIFT stretches latency by exactly 3
    convert(0, 32'h422A_CCCD, 32'h0000_002A, 1'b0, 1'b0, 23, 5);

    // Backpressure in DONE, ignored in_valid pulses, then en=0 freezes DONE despite out_ready
    out_ready_s[0] = 1'b0;
    start(0, 32'h4049_0FDB);
    wait_valid(0, -1, lat);
    $display("inst0 a=40490fdb result=%h latency=%0d (held)", result_s[0], lat);
    chk("bp_latency", 32'(lat), 32'd24);
    for (int j = 0; j < 5; j++) begin
      chk("bp_result_stable", result_s[0], 32'd3);
      chk("bp_in_ready_low", 32'(in_ready_s[0]), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid_s[0]), 32'd1);
      a_s[0]        = 32'h4120_0000;
      in_valid_s[0] = (j % 2 == 0);
      @(negedge clk);
    end
    in_valid_s[0]  = 1'b0;
    en_s[0]        = 1'b0;
    out_ready_s[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("en_low_done_frozen", 32'(out_valid_s[0]), 32'd1);
    end
    en_s[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready_s[0]), 32'd1);

    // Reset mid-SHIFT discards the operation
    start(0, 32'h422A_CCCD);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_idle_zero("midreset");
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      chk("midreset_no_out_valid", 32'(out_valid_s[0]), 32'd0);
    end
    convert(0, 32'h42F6_0000, 32'h0000_007B, 1'b0, 1'b0, 19, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_int_converter.md
FP_TO_INT_CONVERTER -- requirements
Module: fp_to_int_converter

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning bits shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port en  input  1  clock enable; en=0 freezes every register.
REQ-005 SHALL have port a  input  32  IEEE-754 single-precision operand.
REQ-006 SHALL have port in_valid  input  1  a is valid.
REQ-007 SHALL have port in_ready  output  1  converter can accept an operand.
REQ-008 SHALL have port result  output  32  signed two's-complement integer, registered.
REQ-009 SHALL have port overflow  output  1  result saturated, registered.
REQ-010 SHALL have port invalid  output  1  operand was NaN, registered.
REQ-011 SHALL have port out_valid  output  1  result, overflow and invalid are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, FIX and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 SHALL accept an operand on an edge with en && in_valid && in_ready; a is sampled on that edge only.
REQ-015 SHALL decode on accept with s=a[31], e=a[30:23], E=e-127, sig={1,a[22:0]}; rounding is truncation toward zero.
REQ-016 SHALL set result 0, invalid=1, overflow=0 when e==255 and the mantissa is nonzero (NaN).
REQ-017 SHALL saturate when e==255 and the mantissa is zero (infinity): result 0x7FFFFFFF for s=0 and 0x80000000 for s=1, overflow=1.
REQ-018 SHALL give result 0 with no flags when e<127 (zero, denormals, |x|<1); -0 gives 0.
REQ-019 SHALL give 0x80000000 with no flags when s=1, E==31 and the mantissa is zero; every other E>=31 case saturates as in REQ-017 with overflow=1.
REQ-020 SHALL, for 0<=E<=30, shift the magnitude left by k=E-23 when E>=23, otherwise right by k=23-E, with discarded bits dropped.
REQ-021 SHALL go IDLE->SHIFT on accept when the path is numeric and k>0; special, zero and k==0 paths go IDLE->FIX.
REQ-022 SHALL, in SHIFT, shift by min(STEP, remaining) per enabled cycle, and go to FIX when remaining reaches 0.
REQ-023 SHALL, in FIX, load result with s ? -mag : mag (or the special value) and the flags, then go to DONE.
REQ-024 SHALL hold result and flags stable in DONE until en && out_ready, then go to IDLE.
REQ-025 SHALL NOT accept a new operand in the cycle DONE is left; acceptance resumes in IDLE.
REQ-026 SHALL have a latency from the accept edge to out_valid=1 of 2+ceil(k/STEP) enabled edges, and 2 for special, zero and k==0 paths.
REQ-027 SHALL leave state, counters and outputs unchanged when en=0, including in DONE with out_ready=1.
REQ-028 SHALL ignore in_valid outside IDLE, and SHALL NOT stall any state except DONE.

Reset
REQ-029 SHALL, on reset==0 at an edge, set state IDLE, result 0x00000000, overflow 0, invalid 0 and out_valid 0; in_ready=1 follows from IDLE.
REQ-030 SHALL give reset priority over en and any handshake.
REQ-031 SHALL make a reset in SHIFT, FIX or DONE discard the operation with no out_valid pulse.

Verification (STEP=1 unless stated)
REQ-032 SHALL check a=0x422ACCCD (42.7) -> result 0x0000002A, flags 0, out_valid 20 enabled edges after accept.
REQ-033 SHALL check a=0xC16FD708 (-14.99) -> 0xFFFFFFF2; a=0x4EFFFFFF -> 0x7FFFFF80 (k=7, latency 9); repeat both with STEP=4 -> latency 7 and 4 respectively.
REQ-034 SHALL check a=0x4F000000 -> 0x7FFFFFFF with overflow=1; 0xCF000000 -> 0x80000000 with overflow=0; 0x7F800000 -> 0x7FFFFFFF with overflow=1; 0x7F800001 -> 0 with invalid=1; 0x00000000 and 0x3F000000 -> 0 with flags 0 and latency 2.
REQ-035 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 SHALL check en held low 3 cycles mid-SHIFT -> latency grows by exactly 3 and the result is unchanged.
REQ-037 SHALL check reset=0 mid-SHIFT -> IDLE, all outputs 0, no out_valid; the next operand converts correctly.
